// File: rtl/muntjac_metadata_pkg.sv
// ----------------------------------------------------------------------------
// muntjac_metadata_pkg
//
// Shared definitions for the metadata FSM unit:
//   - default encoding widths for states and event codes
//   - the state value used on reset and on a global clear
//   - meta_resp_t, the packed response record {idx, old, new, err} for the
//     default configuration (16 entries, 8-bit states)
// ----------------------------------------------------------------------------
package muntjac_metadata_pkg;

    localparam int unsigned DefNumEntries = 16;
    localparam int unsigned DefIdxW       = $clog2(DefNumEntries);
    localparam int unsigned DefStateW     = 8;
    localparam int unsigned DefEventW     = 4;

    // Every store entry starts here after reset and returns here on clear.
    localparam logic [DefStateW-1:0] StateInit = '0;

    typedef struct packed {
        logic [DefIdxW-1:0]   idx;
        logic [DefStateW-1:0] old_state;
        logic [DefStateW-1:0] new_state;
        logic                 err;
    } meta_resp_t;

endpackage

// File: rtl/muntjac_metadata_trans_table.sv
// ----------------------------------------------------------------------------
// muntjac_metadata_trans_table
//
// Runtime-programmable transition table: next = table[event][state].
// Resets to the identity mapping (table[e][s] = s).
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   cfg_we_i         write enable for one table cell
//   cfg_event_i      row to write
//   cfg_state_i      column to write
//   cfg_next_i       value to store (may be an out-of-range state)
//   rd_event_i       lookup row (combinational read)
//   rd_state_i       lookup column
//   rd_next_o        looked-up next state, or rd_state_i when out of range
//   rd_err_o         event or state outside the table
// ----------------------------------------------------------------------------
module muntjac_metadata_trans_table
    import muntjac_metadata_pkg::*;
#(
    parameter int unsigned NumStates = 4,
    parameter int unsigned NumEvents = 4,
    parameter int unsigned StateW    = DefStateW,
    parameter int unsigned EventW    = DefEventW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_we_i,
    input  logic [EventW-1:0] cfg_event_i,
    input  logic [StateW-1:0] cfg_state_i,
    input  logic [StateW-1:0] cfg_next_i,
    input  logic [EventW-1:0] rd_event_i,
    input  logic [StateW-1:0] rd_state_i,
    output logic [StateW-1:0] rd_next_o,
    output logic              rd_err_o
);

    localparam int unsigned NumCells = NumEvents * NumStates;
    localparam int unsigned CellW    = (NumCells > 1) ? $clog2(NumCells) : 1;

    // Limits carry one extra bit so NumEvents == 2**EventW still fits.
    localparam logic [EventW:0] EventLimit = (EventW + 1)'(NumEvents);
    localparam logic [StateW:0] StateLimit = (StateW + 1)'(NumStates);

    logic [StateW-1:0] cell_q [NumCells];
    logic              wr_in_range;
    logic              rd_in_range;
    logic [CellW-1:0]  wr_cell;
    logic [CellW-1:0]  rd_cell;

    // Cells are laid out row-major: cell = event * NumStates + state.
    always_comb begin
        wr_in_range = ({1'b0, cfg_event_i} < EventLimit) && ({1'b0, cfg_state_i} < StateLimit);
        rd_in_range = ({1'b0, rd_event_i} < EventLimit) && ({1'b0, rd_state_i} < StateLimit);
        wr_cell     = CellW'(32'(cfg_event_i) * NumStates + 32'(cfg_state_i));
        rd_cell     = CellW'(32'(rd_event_i) * NumStates + 32'(rd_state_i));
    end

    genvar gi;
    generate
        for (gi = 0; gi < NumCells; gi++) begin : g_cell
            logic [StateW-1:0] cell_reg;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cell_reg <= StateW'(gi % NumStates);
                end else if (cfg_we_i && wr_in_range && (wr_cell == CellW'(gi))) begin
                    cell_reg <= cfg_next_i;
                end
            end

            assign cell_q[gi] = cell_reg;
        end
    endgenerate

    // Out-of-range lookups leave the state unchanged and raise err; the
    // cell index is only meaningful when the coordinates are in range.
    always_comb begin
        rd_err_o  = !rd_in_range;
        rd_next_o = rd_in_range ? cell_q[rd_cell] : rd_state_i;
    end

endmodule

// File: rtl/muntjac_metadata_fsm_unit.sv
// ----------------------------------------------------------------------------
// muntjac_metadata_fsm_unit
//
// Single owner of per-entry metadata state. Each accepted request applies
// one event to one entry through the programmable transition table and
// returns the state before and after.
//
// Pipeline:
//   S1  holds the accepted {idx, event}; the store read and table lookup
//       happen combinationally in this stage, writeback on S1 advance.
//   S2  registered response {idx, old, new, err}.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_valid_i/ready_o   request handshake; req_idx_i, req_event_i payload
//   resp_valid_o/ready_i  response handshake
//   resp_idx_o            entry index of the response
//   resp_old_state_o      state before the event
//   resp_new_state_o      state after the event
//   resp_err_o            event or stored state out of range
//   cfg_we_i, cfg_event_i, cfg_state_i, cfg_next_i
//                         transition table write port
//   clear_i               synchronous clear of every entry to the init state
// ----------------------------------------------------------------------------
module muntjac_metadata_fsm_unit
    import muntjac_metadata_pkg::*;
#(
    parameter int unsigned NumEntries = 16,
    parameter int unsigned NumStates  = 4,
    parameter int unsigned NumEvents  = 4,
    parameter int unsigned StateW     = DefStateW,
    parameter int unsigned EventW     = DefEventW,
    parameter int unsigned IdxW       = $clog2(NumEntries)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [IdxW-1:0]   req_idx_i,
    input  logic [EventW-1:0] req_event_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [IdxW-1:0]   resp_idx_o,
    output logic [StateW-1:0] resp_old_state_o,
    output logic [StateW-1:0] resp_new_state_o,
    output logic              resp_err_o,
    input  logic              cfg_we_i,
    input  logic [EventW-1:0] cfg_event_i,
    input  logic [StateW-1:0] cfg_state_i,
    input  logic [StateW-1:0] cfg_next_i,
    input  logic              clear_i
);

    localparam logic [StateW-1:0] InitState = StateW'(StateInit);

    // Stage 1
    logic              s1_valid_reg;
    logic [IdxW-1:0]   s1_idx_reg;
    logic [EventW-1:0] s1_event_reg;

    // Stage 2 (response)
    logic              s2_valid_reg;
    logic [IdxW-1:0]   s2_idx_reg;
    logic [StateW-1:0] s2_old_reg;
    logic [StateW-1:0] s2_new_reg;
    logic              s2_err_reg;

    // Handshake and lookup results
    logic              s2_adv;
    logic              s1_adv;
    logic              req_fire;
    logic [StateW-1:0] s1_old_state;
    logic [StateW-1:0] s1_new_state;
    logic              s1_err;

    logic [StateW-1:0] store_q [NumEntries];

    always_comb begin
        s2_adv      = !s2_valid_reg || resp_ready_i;
        s1_adv      = s1_valid_reg && s2_adv;
        req_ready_o = !s1_valid_reg || s2_adv;
        req_fire    = req_valid_i && req_ready_o;
    end

    // ------------------------------------------------------------------
    // Metadata store. Writeback lands on the same edge the next request
    // enters S1, so back-to-back requests to one entry see each other's
    // result without forwarding. Clear beats a coincident writeback.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NumEntries; gi++) begin : g_entry
            logic [StateW-1:0] entry_reg;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    entry_reg <= InitState;
                end else if (clear_i) begin
                    entry_reg <= InitState;
                end else if (s1_adv && (s1_idx_reg == IdxW'(gi))) begin
                    entry_reg <= s1_new_state;
                end
            end

            assign store_q[gi] = entry_reg;
        end
    endgenerate

    assign s1_old_state = store_q[s1_idx_reg];

    // A stored state outside the table (e.g. programmed via cfg_next_i)
    // makes the lookup report err and keep the state as is.
    muntjac_metadata_trans_table #(
        .NumStates (NumStates),
        .NumEvents (NumEvents),
        .StateW    (StateW),
        .EventW    (EventW)
    ) u_trans_table (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_event_i (cfg_event_i),
        .cfg_state_i (cfg_state_i),
        .cfg_next_i  (cfg_next_i),
        .rd_event_i  (s1_event_reg),
        .rd_state_i  (s1_old_state),
        .rd_next_o   (s1_new_state),
        .rd_err_o    (s1_err)
    );

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_reg <= 1'b0;
            s1_idx_reg   <= '0;
            s1_event_reg <= '0;
            s2_valid_reg <= 1'b0;
            s2_idx_reg   <= '0;
            s2_old_reg   <= '0;
            s2_new_reg   <= '0;
            s2_err_reg   <= 1'b0;
        end else begin
            if (req_fire) begin
                s1_valid_reg <= 1'b1;
                s1_idx_reg   <= req_idx_i;
                s1_event_reg <= req_event_i;
            end else if (s1_adv) begin
                s1_valid_reg <= 1'b0;
            end

            if (s1_adv) begin
                s2_valid_reg <= 1'b1;
                s2_idx_reg   <= s1_idx_reg;
                s2_old_reg   <= s1_old_state;
                s2_new_reg   <= s1_new_state;
                s2_err_reg   <= s1_err;
            end else if (s2_adv) begin
                s2_valid_reg <= 1'b0;
            end
        end
    end

    assign resp_valid_o     = s2_valid_reg;
    assign resp_idx_o       = s2_idx_reg;
    assign resp_old_state_o = s2_old_reg;
    assign resp_new_state_o = s2_new_reg;
    assign resp_err_o       = s2_err_reg;

endmodule
